// File: rtl/data_mem_responder_if.sv
// Pipeline memory-stage bus between the core (master) and the data memory responder (slave).
interface data_mem_responder_if;
    logic        mem_enM;
    logic [31:0] mem_addrM;
    logic [3:0]  mem_wenM;
    logic [31:0] mem_wdataM;
    logic [31:0] mem_rdataM;
    logic        d_cache_stall;

    modport master (
        output mem_enM, mem_addrM, mem_wenM, mem_wdataM,
        input  mem_rdataM, d_cache_stall
    );

    modport slave (
        input  mem_enM, mem_addrM, mem_wenM, mem_wdataM,
        output mem_rdataM, d_cache_stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory: accepts one access, stalls the pipeline for 1+LATENCY cycles,
// performs the byte-masked write or word read on entry to DONE.
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input logic               clk,
    input logic               rst,
    data_mem_responder_if.slave bus_s
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          wen_q, wen_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                access_c;
    logic                stall_c;
    logic [31:0]         mem_q [DEPTH];

    // Only the word-address bits inside the storage are decoded; the rest alias.
    logic unused_addr;
    assign unused_addr = ^{bus_s.mem_addrM[31:ADDR_W+2], bus_s.mem_addrM[1:0]};

    // Next-state, request latching and stall generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        access_c = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_s.mem_enM) begin
                    stall_c = 1'b1;
                    addr_d  = bus_s.mem_addrM[ADDR_W+1:2];
                    wen_d   = bus_s.mem_wenM;
                    wdata_d = bus_s.mem_wdataM;
                    cnt_d   = CNT_W'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d  = DONE;
                        access_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    access_c = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The access uses the values being latched on this edge, so LATENCY=0 needs no bypass.
    always_comb begin
        rdata_d = rdata_q;
        if (access_c && (wen_d == 4'b0000)) begin
            rdata_d = mem_q[addr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage survives reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (access_c && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wen_d[i]) begin
                    mem_q[addr_d][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    assign bus_s.mem_rdataM    = rdata_q;
    assign bus_s.d_cache_stall = stall_c;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: LATENCY=0 and LATENCY=2 instances against a transaction-level model.
module tb_data_mem_responder;
    logic clk;
    logic rst;

    data_mem_responder_if if0 ();
    data_mem_responder_if if2 ();

    data_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus_s(if0));
    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus_s(if2));

    int checks = 0;
    int errors = 0;

    logic        exp_stall [2];
    logic [31:0] exp_rdata [2];
    logic [31:0] model_mem [2][1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    task automatic drive(input int k, input logic en, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d);
        if (k == 0) begin
            if0.mem_enM = en; if0.mem_addrM = a; if0.mem_wenM = w; if0.mem_wdataM = d;
        end else begin
            if2.mem_enM = en; if2.mem_addrM = a; if2.mem_wenM = w; if2.mem_wdataM = d;
        end
    endtask

    // One complete access; called #1 after a rising edge with the DUT idle.
    task automatic access(input int k, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] d, input bit perturb);
        int ix;
        ix = widx(a);
        drive(k, 1'b1, a, w, d);
        exp_stall[k] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < lat_of(k); i++) begin
            if (perturb) drive(k, 1'b1, a ^ 32'h0000_0008, ~w, ~d);
            @(posedge clk); #1;
        end
        if (w == 4'b0000) begin
            exp_rdata[k] = model_mem[k][ix];
        end else begin
            for (int b = 0; b < 4; b++)
                if (w[b]) model_mem[k][ix][8*b +: 8] = d[8*b +: 8];
        end
        exp_stall[k] = 1'b0;
        // Request still asserted (different address) during DONE; it must be ignored.
        drive(k, 1'b1, a ^ 32'h0000_0100, w, ~d);
        @(posedge clk); #1;
        drive(k, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        chk("stall_lat0", {31'b0, if0.d_cache_stall}, {31'b0, exp_stall[0]});
        chk("rdata_lat0", if0.mem_rdataM, exp_rdata[0]);
        chk("stall_lat2", {31'b0, if2.d_cache_stall}, {31'b0, exp_stall[2-1]});
        chk("rdata_lat2", if2.mem_rdataM, exp_rdata[1]);
    end

    initial begin
        rst = 1'b1;
        exp_stall[0] = 1'b0; exp_stall[1] = 1'b0;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_rdata", if2.mem_rdataM, 32'h0);
        chk("reset_stall", {31'b0, if2.d_cache_stall}, 32'h0);

        access(1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        access(1, 32'h20, 4'hF, 32'h11223344, 1'b0);
        access(1, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("read_deadbeef", if2.mem_rdataM, 32'hDEADBEEF);
        access(1, 32'h20, 4'b0010, 32'h0000AA00, 1'b0);
        chk("rdata_held_after_write", if2.mem_rdataM, 32'hDEADBEEF);
        access(1, 32'h20, 4'h0, 32'h0, 1'b0);
        chk("byte_write", if2.mem_rdataM, 32'h1122AA44);

        access(1, 32'h14, 4'hF, 32'hCAFEF00D, 1'b0);
        access(1, 32'h10, 4'h0, 32'h0, 1'b0);
        access(1, 32'h14, 4'h0, 32'h0, 1'b0);
        chk("back_to_back", if2.mem_rdataM, 32'hCAFEF00D);

        access(1, 32'h18, 4'hF, 32'h12345678, 1'b1);
        access(1, 32'h18, 4'h0, 32'h0, 1'b1);
        chk("latched_inputs", if2.mem_rdataM, 32'h12345678);
        access(1, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("no_stray_write", if2.mem_rdataM, 32'hDEADBEEF);

        access(1, 32'h1C, 4'hF, 32'h00000000, 1'b0);
        access(1, 32'h1C, 4'b1001, 32'hAABBCCDD, 1'b0);
        access(1, 32'h1C, 4'h0, 32'h0, 1'b0);
        chk("mixed_wen", if2.mem_rdataM, 32'hAA0000DD);

        access(1, 32'h30, 4'hF, 32'h0A0A0A0A, 1'b0);
        drive(1, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF);
        exp_stall[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        exp_stall[1] = 1'b0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        #1;
        chk("rst_wait_stall", {31'b0, if2.d_cache_stall}, 32'h0);
        chk("rst_wait_rdata", if2.mem_rdataM, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        access(1, 32'h30, 4'h0, 32'h0, 1'b0);
        chk("rst_no_write", if2.mem_rdataM, 32'h0A0A0A0A);

        access(1, 32'h1000_0040, 4'hF, 32'h5A5A1234, 1'b0);
        access(1, 32'h43, 4'h0, 32'h0, 1'b0);
        chk("alias_high_bits", if2.mem_rdataM, 32'h5A5A1234);
        access(1, 32'h1000, 4'hF, 32'h0BADC0DE, 1'b0);
        access(1, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("alias_wrap", if2.mem_rdataM, 32'h0BADC0DE);

        access(0, 32'h80, 4'hF, 32'h87654321, 1'b0);
        access(0, 32'h80, 4'h0, 32'h0, 1'b0);
        chk("lat0_read", if0.mem_rdataM, 32'h87654321);
        access(0, 32'h84, 4'hF, 32'h0F0F0F0F, 1'b0);
        access(0, 32'h84, 4'h0, 32'h0, 1'b0);
        access(0, 32'h80, 4'h0, 32'h0, 1'b0);
        chk("lat0_back_to_back", if0.mem_rdataM, 32'h87654321);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
